// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage with IF/ID pipeline register
//
// Holds the PC, drives the instruction-memory address, and latches the
// fetched word plus PC+4 into IF/ID. Control-flow redirects from the
// resolving stage (BEQ/J/JAL/JR) override stall and flush the IF/ID slot.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   imem_addr     instruction-memory byte address (= PC)
//   imem_instr    instruction word at imem_addr (combinational read)
//   stall         hold PC and IF/ID
//   redirect      control-flow instruction resolving this cycle
//   jump_type     0 NOP, 1 BEQ, 2 JAL, 3 JR, 4 J
//   jump_addr     J/JAL instruction index
//   br_imm        sign-extended BEQ word offset
//   br_pc4        PC+4 of the resolving instruction
//   rs1_data      forwarded JR target
//   br_eq         BEQ compare result
//   id_instr      IF/ID instruction
//   id_pc4        IF/ID PC+4
//   id_valid      IF/ID holds a real instruction
//   taken         redirect accepted this cycle (combinational)
module fetch_stage #(
  parameter int                 DWIDTH   = 32,
  parameter logic [DWIDTH-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic [DWIDTH-1:0] imem_instr,
  input  logic              stall,
  input  logic              redirect,
  input  logic [2:0]        jump_type,
  input  logic [25:0]       jump_addr,
  input  logic [DWIDTH-1:0] br_imm,
  input  logic [DWIDTH-1:0] br_pc4,
  input  logic [DWIDTH-1:0] rs1_data,
  input  logic              br_eq,
  output logic [DWIDTH-1:0] id_instr,
  output logic [DWIDTH-1:0] id_pc4,
  output logic              id_valid,
  output logic              taken
);

  localparam logic [2:0] JT_BEQ = 3'd1;
  localparam logic [2:0] JT_JAL = 3'd2;
  localparam logic [2:0] JT_JR  = 3'd3;
  localparam logic [2:0] JT_J   = 3'd4;

  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] id_instr_q, id_instr_d;
  logic [DWIDTH-1:0] id_pc4_q, id_pc4_d;
  logic              id_valid_q, id_valid_d;
  logic [DWIDTH-1:0] target;
  logic [DWIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + DWIDTH'(4);

  // Codes 0 and 5..7 fall through to not-taken.
  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (jump_type)
      JT_BEQ: begin
        taken  = redirect & br_eq;
        target = br_pc4 + (br_imm << 2);
      end
      JT_JAL, JT_J: begin
        taken  = redirect;
        target = {br_pc4[DWIDTH-1:28], jump_addr, 2'b00};
      end
      JT_JR: begin
        taken  = redirect;
        // Misaligned JR targets are silently aligned rather than trapped.
        target = {rs1_data[DWIDTH-1:2], 2'b00};
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

  // Redirect beats stall: a stalled instruction behind a taken branch is
  // on the wrong path anyway, so it is flushed instead of held.
  always_comb begin
    pc_d       = pc_plus4;
    id_instr_d = imem_instr;
    id_pc4_d   = pc_plus4;
    id_valid_d = 1'b1;
    if (taken) begin
      pc_d       = target;
      id_instr_d = '0;
      id_pc4_d   = '0;
      id_valid_d = 1'b0;
    end else if (stall) begin
      pc_d       = pc_q;
      id_instr_d = id_instr_q;
      id_pc4_d   = id_pc4_q;
      id_valid_d = id_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_instr_q <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [2:0]  jump_type;
  logic [25:0] jump_addr;
  logic [31:0] br_imm;
  logic [31:0] br_pc4;
  logic [31:0] rs1_data;
  logic        br_eq;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        taken;

  int vectors;
  int miscompares;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  fetch_stage #(.DWIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .redirect(redirect), .jump_type(jump_type),
    .jump_addr(jump_addr), .br_imm(br_imm), .br_pc4(br_pc4),
    .rs1_data(rs1_data), .br_eq(br_eq), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_valid(id_valid), .taken(taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F81;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  function automatic logic exp_taken(input logic r, input logic [2:0] jt, input logic eq);
    return r && (jt == 3'd2 || jt == 3'd3 || jt == 3'd4 || (jt == 3'd1 && eq));
  endfunction

  function automatic logic [31:0] exp_target(input logic [2:0] jt);
    case (jt)
      3'd1:       return br_pc4 + {br_imm[29:0], 2'b00};
      3'd2, 3'd4: return {br_pc4[31:28], jump_addr, 2'b00};
      default:    return {rs1_data[31:2], 2'b00};
    endcase
  endfunction

  task automatic idle_inputs();
    stall = 0; redirect = 0; jump_type = 0; jump_addr = 0;
    br_imm = 0; br_pc4 = 0; rs1_data = 0; br_eq = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0;
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    logic tk;
    #1;
    tk = exp_taken(redirect, jump_type, br_eq);
    vectors++;
    if (taken !== tk) begin
      miscompares++;
      $display("FAIL %s.taken got %b want %b", tag, taken, tk);
    end
    vectors++;
    if (imem_addr !== m_pc) begin
      miscompares++;
      $display("FAIL %s.imem_addr_pre got %h want %h", tag, imem_addr, m_pc);
    end
    if (tk) begin
      e.pc = exp_target(jump_type); e.instr = 0; e.pc4 = 0; e.valid = 0;
    end else if (stall) begin
      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    end else begin
      e.pc = m_pc + 32'd4; e.instr = mem_word(m_pc); e.pc4 = m_pc + 32'd4; e.valid = 1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if (imem_addr !== e.pc) begin
      miscompares++;
      $display("FAIL %s.pc got %h want %h", tag, imem_addr, e.pc);
    end
    vectors++;
    if (id_instr !== e.instr) begin
      miscompares++;
      $display("FAIL %s.id_instr got %h want %h", tag, id_instr, e.instr);
    end
    vectors++;
    if (id_pc4 !== e.pc4) begin
      miscompares++;
      $display("FAIL %s.id_pc4 got %h want %h", tag, id_pc4, e.pc4);
    end
    vectors++;
    if (id_valid !== e.valid) begin
      miscompares++;
      $display("FAIL %s.id_valid got %b want %b", tag, id_valid, e.valid);
    end
    m_pc = e.pc; m_instr = e.instr; m_pc4 = e.pc4; m_valid = e.valid;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #12;
    check_val("reset.imem_addr", imem_addr, 32'h0);
    check_val("reset.id_instr", id_instr, 32'h0);
    check_val("reset.id_pc4", id_pc4, 32'h0);
    check_val("reset.id_valid", {31'b0, id_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      step("seq");
      check_val("seq.imem_addr", imem_addr, 32'(4 * i));
      check_val("seq.id_pc4", id_pc4, 32'(4 * i));
      check_val("seq.id_valid", {31'b0, id_valid}, 32'h1);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = id_instr;
    check_val("stall.start_pc", imem_addr, 32'h10);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check_val("stall.imem_addr", imem_addr, 32'h10);
      check_val("stall.id_instr", id_instr, held);
    end
    stall = 0;
    step("stall_release");
    check_val("stall.release_pc", imem_addr, 32'h14);
  endtask

  task automatic test_beq();
    redirect = 1; jump_type = 3'd1; br_pc4 = 32'h20; br_imm = 32'hFFFF_FFFE; br_eq = 1;
    #1;
    check_val("beq.taken", {31'b0, taken}, 32'h1);
    step("beq_taken");
    check_val("beq.pc", imem_addr, 32'h18);
    check_val("beq.flush", {31'b0, id_valid}, 32'h0);
    br_eq = 0;
    step("beq_not_taken");
    check_val("beq_nt.pc", imem_addr, 32'h1C);
    check_val("beq_nt.valid", {31'b0, id_valid}, 32'h1);
    idle_inputs();
    step("beq_after");
  endtask

  task automatic test_jumps();
    redirect = 1; jump_type = 3'd4; jump_addr = 26'h0000040; br_pc4 = 32'h3000_0000;
    step("j");
    check_val("j.pc", imem_addr, 32'h3000_0100);
    jump_type = 3'd3; rs1_data = 32'h203;
    step("jr_back_to_back");
    check_val("jr.pc", imem_addr, 32'h200);
    // Non-jump codes must never be taken even with redirect high.
    for (int jt = 0; jt < 8; jt++) begin
      if (jt >= 1 && jt <= 4) continue;
      jump_type = 3'(jt);
      step("nontaken_code");
    end
    idle_inputs();
    step("jumps_after");
  endtask

  task automatic test_jal_stall();
    redirect = 1; stall = 1; jump_type = 3'd2;
    jump_addr = 26'h3FF_FFFF; br_pc4 = 32'hF000_0000;
    step("jal_stall");
    check_val("jal_stall.pc", imem_addr, 32'hFFFF_FFFC);
    check_val("jal_stall.flush_instr", id_instr, 32'h0);
    idle_inputs();
    step("wrap");
    check_val("wrap.pc", imem_addr, 32'h0);
    check_val("wrap.id_pc4", id_pc4, 32'h0);
    step("wrap_next");
  endtask

  task automatic test_reset_mid();
    step("pre_rst");
    redirect = 1; jump_type = 3'd4; jump_addr = 26'h123;
    #2;
    rst = 1;
    #1;
    check_val("rst_mid.imem_addr", imem_addr, 32'h0);
    check_val("rst_mid.id_valid", {31'b0, id_valid}, 32'h0);
    check_val("rst_mid.id_instr", id_instr, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    model_reset();
    step("post_rst");
    step("post_rst2");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_beq();
    test_jumps();
    test_jal_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
